// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// The master (EX stage) issues operations. The slave (muldiv_unit) reports busy, done and result.
interface muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit.
// It has one shift-add multiplier, one restoring divider and a shared iteration counter.
// Arithmetic runs on operand magnitudes. The sign is applied in the FIX state.
// Divide by zero and signed overflow bypass the iteration and go straight to DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [2:0]        f3_reg;
  logic              a_neg_reg, b_neg_reg;
  // Multiplicand for multiplies, divisor for divides (both as magnitudes).
  logic [XLEN-1:0]   mcand_reg;
  // Product for multiplies. For divides it holds the remainder in the high half and the quotient in the low half.
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   result_reg;

  // Request decode for the operation presented in IDLE.
  logic              accept;
  logic              is_div_in, sign_a_in, sign_b_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              div_zero_in, div_ovf_in, fast_in;
  logic [XLEN-1:0]   fast_result;

  // One iteration of each datapath.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quot_signed, rem_signed, fix_result;

  logic              busy_int, done_int;

  assign accept    = (state_reg == IDLE) && bus.start && !bus.flush;
  assign is_div_in = bus.funct3[2];
  // The signed forms are MULH, MULHSU, DIV and REM. MULHSU is signed only in op_a.
  assign sign_a_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign sign_b_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                     (bus.funct3 == 3'b110);
  assign a_neg_in  = sign_a_in && bus.op_a[XLEN-1];
  assign b_neg_in  = sign_b_in && bus.op_b[XLEN-1];
  assign a_mag_in  = a_neg_in ? (~bus.op_a + 1'b1) : bus.op_a;
  assign b_mag_in  = b_neg_in ? (~bus.op_b + 1'b1) : bus.op_b;

  assign div_zero_in = is_div_in && (bus.op_b == '0);
  // Only the signed forms (funct3[0] == 0) can overflow: the most negative value divided by -1.
  assign div_ovf_in  = is_div_in && !bus.funct3[0] &&
                       (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (bus.op_b == {XLEN{1'b1}});
  assign fast_in     = div_zero_in || div_ovf_in;
  // funct3[1] selects the remainder forms.
  // On divide by zero, the quotient is all-ones and the remainder is the dividend.
  // On overflow, the quotient is the dividend (the most negative value) and the remainder is zero.
  assign fast_result = div_zero_in ? (bus.funct3[1] ? bus.op_a : {XLEN{1'b1}})
                                   : (bus.funct3[1] ? '0 : bus.op_a);

  // Shift-add step: add the multiplicand when the multiplier LSB is 1, then shift right.
  assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                    (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

  // Restoring step: shift remainder:quotient left and try to subtract the divisor.
  assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, mcand_reg};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};

  // The neg flags are zero for the unsigned forms, so one xor covers all multiplies.
  assign prod_signed = (a_neg_reg ^ b_neg_reg) ? (~acc_reg + 1'b1) : acc_reg;
  assign quot_signed = (a_neg_reg ^ b_neg_reg) ? (~acc_reg[XLEN-1:0] + 1'b1)
                                               : acc_reg[XLEN-1:0];
  assign rem_signed  = a_neg_reg ? (~acc_reg[2*XLEN-1:XLEN] + 1'b1)
                                 : acc_reg[2*XLEN-1:XLEN];

  // Select the architectural result for the latched funct3.
  always_comb begin
    fix_result = '0;
    case (f3_reg)
      3'b000:                 fix_result = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quot_signed;
      default:                fix_result = rem_signed;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and the busy/done outputs. A flush forces IDLE from any state.
  always_comb begin
    state_next = state_reg;
    busy_int   = (state_reg != IDLE);
    done_int   = (state_reg == DONE);
    case (state_reg)
      IDLE: if (accept) state_next = fast_in ? DONE : CALC;
      CALC: if (cnt_reg == CW'(XLEN-1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // Datapath: capture operands on accept, iterate in CALC, and latch the result in FIX or on the fast path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      f3_reg     <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            f3_reg    <= bus.funct3;
            a_neg_reg <= a_neg_in;
            b_neg_reg <= b_neg_in;
            cnt_reg   <= '0;
            if (is_div_in) begin
              mcand_reg <= b_mag_in;
              acc_reg   <= {{XLEN{1'b0}}, a_mag_in};
            end else begin
              mcand_reg <= a_mag_in;
              acc_reg   <= {{XLEN{1'b0}}, b_mag_in};
            end
            if (fast_in) result_reg <= fast_result;
          end
        end
        CALC: begin
          acc_reg <= f3_reg[2] ? div_next : mul_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          if (!bus.flush) result_reg <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = busy_int;
  assign bus.done   = done_int;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit.
// It covers latency, signed and unsigned forms, the divide fast paths, flush, reset, ignored starts and back-to-back operation.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure done-pulse spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait for done.
  // Checks: busy after accept, start-to-done latency, result, single-cycle done, and return to idle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    step();
    bus.start = 1'b0;
    check({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
    n = 1;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, bus.result, exp);
    step();
    check({tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
    check({tag, " idle"}, {31'b0, bus.busy}, 32'd0);
    $display("[TB] %s f3=%b a=%h b=%h result=%h latency=%0d", tag, f3, a, b, bus.result, n);
  endtask

  initial begin
    int done_seen;
    int n;
    int t1;
    int t2;
    logic [31:0] held;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    step();
    step();
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    $display("[TB] reset busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
    rst_n = 1'b1;
    step();

    run_op("MUL 7*-3",     3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHU",        3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("MULHSU",       3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34);
    run_op("DIV -20/6",    3'b100, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 34);
    run_op("REM -20/6",    3'b110, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 34);
    run_op("DIVU -20/6",   3'b101, 32'hFFFF_FFEC, 32'd6,         32'h2AAA_AAA7, 34);
    run_op("DIVU x/0",     3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
    run_op("REM 5/0",      3'b110, 32'd5,         32'd0,         32'd5,         1);
    run_op("DIV ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("DIVU 100/7",   3'b101, 32'd100,       32'd7,         32'd14,        34);

    // Flush at CALC iteration 10: the unit returns to idle, no done follows, and the result is held.
    held = 32'd14;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b101;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd3;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush busy", {31'b0, bus.busy}, 32'd0);
    check("flush done", {31'b0, bus.done}, 32'd0);
    check("flush result", bus.result, held);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) done_seen++;
    end
    check("flush no done", done_seen, 32'd0);
    check("flush result held", bus.result, held);
    $display("[TB] flush at iteration 10 result=%h done_seen=%0d", bus.result, done_seen);

    // Reset at CALC iteration 20: all outputs clear and no done follows.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd123;
    bus.op_b   = 32'd456;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst_n = 1'b0;
    step();
    check("midrst busy", {31'b0, bus.busy}, 32'd0);
    check("midrst done", {31'b0, bus.done}, 32'd0);
    check("midrst result", bus.result, 32'd0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) done_seen++;
    end
    check("midrst no done", done_seen, 32'd0);
    $display("[TB] reset at iteration 20 result=%h done_seen=%0d", bus.result, done_seen);

    // A start pulsed while busy is ignored: the result stays at its value and only one done occurs.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd9;
    bus.op_b   = 32'd9;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    bus.start = 1'b1;
    bus.op_a  = 32'd1;
    bus.op_b  = 32'd1;
    step();
    step();
    bus.start = 1'b0;
    check("ignored start result", bus.result, 32'd0);
    n = 0;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    check("ignored start done seen", {31'b0, bus.done}, 32'd1);
    check("ignored start final", bus.result, 32'd81);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) done_seen++;
    end
    check("ignored start no 2nd done", done_seen, 32'd0);
    $display("[TB] ignored start result=%h extra_done=%0d", bus.result, done_seen);

    // Back-to-back MULs. The second start is held from the DONE cycle and is accepted in the following idle cycle.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd4;
    step();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    t1 = cyc;
    check("b2b first", bus.result, 32'd12);
    bus.start = 1'b1;
    bus.op_a  = 32'd5;
    bus.op_b  = 32'd6;
    step();
    step();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    t2 = cyc;
    check("b2b second", bus.result, 32'd30);
    check("b2b spacing", t2 - t1, 32'd35);
    $display("[TB] back-to-back results 12/30 second=%h spacing=%0d", bus.result, t2 - t1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
